// File: rtl/fp16_to_int.sv
// fp16_to_int: iterative IEEE754 binary16 to 16-bit signed integer decoder.
// A request latches the operand, UNPACK classifies the exponent, SHIFT moves
// the significand one bit position per clock, and SIGN applies the sign and
// emits a one-cycle R_O strobe, with ERROR for Inf, NaN or out-of-range input.
//
// Optional feature macro: FP16_ROUND_EN
//   undefined : truncation toward zero, no guard register
//   defined   : round half away from zero using the last discarded bit
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for R_I; the only state in which a request is taken
// UNPACK | classify exponent, load work register and shift count
// SHIFT  | shift work register one position per clock until count hits 0
// SIGN   | apply sign (or load saturated value), pulse R_O / ERROR

module fp16_to_int (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] dataIn,
  input  logic        R_I,
  output logic [15:0] dataOut,
  output logic        R_O,
  output logic        ERROR,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNPACK = 2'd1,
    SHIFT  = 2'd2,
    SIGN   = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] operand;
  logic [15:0] work;
  logic [3:0]  cnt;
  logic        shift_left;
  logic        err_flag;
  logic        direct;
`ifdef FP16_ROUND_EN
  logic        guard;
`endif

  logic        sgn;
  logic [4:0]  exp_f;
  logic [9:0]  frac;
  logic [15:0] sat_val;

  logic [15:0] dec_work;
  logic [3:0]  dec_cnt;
  logic        dec_left;
  logic        dec_err;
  logic        dec_direct;

  logic [15:0] mag;

  assign sgn     = operand[15];
  assign exp_f   = operand[14:10];
  assign frac    = operand[9:0];
  assign sat_val = sgn ? 16'h8000 : 16'h7FFF;

  // Exponent classification: decides the work register load, shift count
  // and direction, and whether the result is an error value loaded as-is.
  always_comb begin
    dec_work   = 16'h0000;
    dec_cnt    = 4'd0;
    dec_left   = 1'b0;
    dec_err    = 1'b0;
    dec_direct = 1'b0;
    if (exp_f == 5'd31) begin
      // Inf saturates by sign; NaN returns zero
      dec_err    = 1'b1;
      dec_direct = 1'b1;
      dec_work   = (frac != 10'd0) ? 16'h0000 : sat_val;
    end else if (exp_f == 5'd30) begin
      if (operand == 16'hF800) begin
        // -32768 is the only representable e=30 value
        dec_work = 16'h0400;
        dec_cnt  = 4'd5;
        dec_left = 1'b1;
      end else begin
        dec_err    = 1'b1;
        dec_direct = 1'b1;
        dec_work   = sat_val;
      end
    end else if (exp_f >= 5'd15) begin
      dec_work = {5'b00000, 1'b1, frac};
      if (exp_f > 5'd25) begin
        dec_left = 1'b1;
        dec_cnt  = 4'(exp_f - 5'd25);
      end else begin
        dec_cnt  = 4'(5'd25 - exp_f);
      end
`ifdef FP16_ROUND_EN
    end else if (exp_f == 5'd14) begin
      // all eleven significand bits shift out; hidden bit ends up as guard
      dec_work = {5'b00000, 1'b1, frac};
      dec_cnt  = 4'd11;
`endif
    end else begin
      dec_work = 16'h0000;
    end
  end

  // Magnitude presented to the sign stage, including the rounding increment.
  always_comb begin
`ifdef FP16_ROUND_EN
    mag = work + {15'd0, guard};
`else
    mag = work;
`endif
  end

  // Main controller: state, operand capture, shifting and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      operand    <= 16'h0000;
      work       <= 16'h0000;
      cnt        <= 4'd0;
      shift_left <= 1'b0;
      err_flag   <= 1'b0;
      direct     <= 1'b0;
`ifdef FP16_ROUND_EN
      guard      <= 1'b0;
`endif
      dataOut    <= 16'h0000;
      R_O        <= 1'b0;
      ERROR      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      R_O   <= 1'b0;
      ERROR <= 1'b0;
      case (state)
        IDLE: begin
          if (R_I) begin
            operand <= dataIn;
            busy    <= 1'b1;
            state   <= UNPACK;
          end
        end
        UNPACK: begin
          work       <= dec_work;
          cnt        <= dec_cnt;
          shift_left <= dec_left;
          err_flag   <= dec_err;
          direct     <= dec_direct;
`ifdef FP16_ROUND_EN
          guard      <= 1'b0;
`endif
          state      <= (dec_cnt == 4'd0) ? SIGN : SHIFT;
        end
        SHIFT: begin
          if (shift_left) begin
            work <= {work[14:0], 1'b0};
          end else begin
            work <= {1'b0, work[15:1]};
`ifdef FP16_ROUND_EN
            guard <= work[0];
`endif
          end
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          if (direct) begin
            dataOut <= work;
          end else if (sgn) begin
            dataOut <= ~mag + 16'd1;
          end else begin
            dataOut <= mag;
          end
          R_O   <= 1'b1;
          ERROR <= err_flag;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_to_int.sv
// Testbench for fp16_to_int: directed and random binary16 operands checked
// against an arithmetic reference model (value range, scaling by powers of
// two), including latency, busy duration, request masking and reset abort.
// Honours FP16_ROUND_EN in the same way as the design.

module tb_fp16_to_int;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] dataIn = 16'h0000;
  logic        R_I = 1'b0;
  logic [15:0] dataOut;
  logic        R_O;
  logic        ERROR;
  logic        busy;

  int errors = 0;
  int checks = 0;

  fp16_to_int dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dataIn  (dataIn),
    .R_I     (R_I),
    .dataOut (dataOut),
    .R_O     (R_O),
    .ERROR   (ERROR),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer value of the half-precision number from its real
  // magnitude (1.frac * 2^(e-15)), then range check for the 16-bit result.
  function automatic void model(input logic [15:0] op, output logic [15:0] res,
                                output logic err, output int lat);
    int e;
    int frac;
    int m;
    int mag;
    int limit;
    int k;
    bit s;
    e    = int'(op[14:10]);
    frac = int'(op[9:0]);
    s    = op[15];
    m    = 1024 + frac;
    err  = 1'b0;
    k    = 0;
    mag  = 0;
    if (e == 31) begin
      err = 1'b1;
      res = (frac != 0) ? 16'h0000 : (s ? 16'h8000 : 16'h7FFF);
    end else begin
      if (e == 0) mag = 0;
      else if (e >= 25) mag = m << (e - 25);
`ifdef FP16_ROUND_EN
      else mag = (((m * 2) >> (25 - e)) + 1) >> 1;
`else
      else mag = m >> (25 - e);
`endif
      limit = s ? 32768 : 32767;
      if (mag > limit) begin
        err = 1'b1;
        res = s ? 16'h8000 : 16'h7FFF;
      end else begin
        res = s ? 16'(-mag) : 16'(mag);
      end
    end
    if (e == 30) k = (s && frac == 0) ? 5 : 0;
    else if (e >= 15 && e <= 29) k = (e > 25) ? (e - 25) : (25 - e);
`ifdef FP16_ROUND_EN
    else if (e == 14) k = 11;
`endif
    else k = 0;
    lat = 3 + k;
  endfunction

  // Issue one request and check result, error, latency (edges counted from
  // the sampling edge as 1) and number of busy cycles. With intrude set, a
  // different operand is strobed while the converter is busy.
  task automatic run_op(input logic [15:0] op, input bit chained, input bit intrude);
    logic [15:0] eres;
    logic        eerr;
    int          elat;
    int          lat;
    int          busy_cnt;
    model(op, eres, eerr, elat);
    if (!chained) @(negedge clk);
    dataIn = op;
    R_I    = 1'b1;
    @(posedge clk);
    #1;
    R_I      = 1'b0;
    lat      = 1;
    busy_cnt = busy ? 1 : 0;
    while (!R_O && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (!R_O && busy) busy_cnt++;
      if (intrude && lat == 3) begin
        dataIn = 16'hC500;
        R_I    = 1'b1;
      end else begin
        R_I = 1'b0;
      end
    end
    R_I = 1'b0;
    check($sformatf("data_%04h", op), {16'h0, dataOut}, {16'h0, eres});
    check($sformatf("err_%04h", op), {31'h0, ERROR}, {31'h0, eerr});
    check($sformatf("lat_%04h", op), lat, elat);
    check($sformatf("busy_%04h", op), busy_cnt, elat - 1);
    check($sformatf("busy_fall_%04h", op), {31'h0, busy}, 32'h0);
  endtask

  task automatic check_pulse_end(input string tag);
    @(posedge clk);
    #1;
    check(tag, {31'h0, R_O}, 32'h0);
  endtask

  initial begin
    logic [15:0] rop;
    #1;
    check("reset_data", {16'h0, dataOut}, 32'h0);
    check("reset_ro", {31'h0, R_O}, 32'h0);
    check("reset_err", {31'h0, ERROR}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_op(16'h3C00, 1'b0, 1'b0);
    check_pulse_end("ro_one_cycle");
    run_op(16'hC500, 1'b0, 1'b0);
    run_op(16'hF800, 1'b0, 1'b0);
    run_op(16'h7BFF, 1'b0, 1'b0);
    run_op(16'h7E00, 1'b0, 1'b0);
    run_op(16'hFC00, 1'b0, 1'b0);
    run_op(16'h7C00, 1'b0, 1'b0);
    run_op(16'h7800, 1'b0, 1'b0);
    run_op(16'h3800, 1'b0, 1'b0);
    run_op(16'h3E00, 1'b0, 1'b0);
    run_op(16'h8000, 1'b0, 1'b0);
    run_op(16'h0001, 1'b0, 1'b0);
    run_op(16'h77FF, 1'b0, 1'b0);
    run_op(16'hF7FF, 1'b0, 1'b0);
    run_op(16'h6400, 1'b0, 1'b0);

    // request while busy is ignored
    run_op(16'h3C00, 1'b0, 1'b1);
    check_pulse_end("ignored_req_no_second");

    // back-to-back: second request presented on the R_O cycle
    run_op(16'h4000, 1'b0, 1'b0);
    run_op(16'hC500, 1'b1, 1'b0);
    run_op(16'h3C00, 1'b1, 1'b0);

    // reset during SHIFT aborts the conversion
    run_op(16'hC500, 1'b0, 1'b0);
    @(negedge clk);
    dataIn = 16'h3C00;
    R_I    = 1'b1;
    @(posedge clk);
    #1;
    R_I = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_data", {16'h0, dataOut}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_ro", {31'h0, R_O}, 32'h0);
    check("abort_err", {31'h0, ERROR}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("abort_ro_hold", {31'h0, R_O}, 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_late_ro", {31'h0, R_O}, 32'h0);
    end
    run_op(16'h3C00, 1'b0, 1'b0);

    // random operands across all exponents
    for (int i = 0; i < 60; i++) begin
      rop = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 10'($urandom_range(0, 1023))};
      run_op(rop, (i % 3) == 1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
